rgb_2_rgbw_conv: RTL and testbench

//  Colour-conversion stage between async_fifo read port and rgb_sotp. Pops 24-bit GRB pixel words,

---
 rtl/rgbw_pkg.sv | 56 +++++
 rtl/rgbw_out_buf.sv | 65 ++++++
 rtl/rgb_2_rgbw_conv.sv | 110 +++++++++++
 tb/tb_rgb_2_rgbw_conv.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgbw_pkg.sv
// Shared lane positions, word layouts and helpers for the GRB -> GRBW colour stage.
// No logic, no latency.
// No backpressure: types and functions only.
package rgbw_pkg;

    localparam int PIX_W        = 8;
    localparam int IN_W         = 32;
    localparam int GRBW_W       = 32;
    localparam int STRM_RST_BIT = 24;

    // Input word lanes: [23:16]=G [15:8]=R [7:0]=B
    localparam int G_IN_LSB = 16;
    localparam int R_IN_LSB = 8;
    localparam int B_IN_LSB = 0;

    // Output word lanes: [31:24]=G' [23:16]=R' [15:8]=B' [7:0]=W
    localparam int G_OUT_LSB = 24;
    localparam int R_OUT_LSB = 16;
    localparam int B_OUT_LSB = 8;
    localparam int W_OUT_LSB = 0;

    typedef struct packed {
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] b;
    } pix_t;

    // Registered between the min stage and the output stage.
    typedef struct packed {
        logic             tok;
        logic             byp;
        pix_t             pix;
        logic [PIX_W-1:0] m;
    } stage_t;

    // One output buffer entry.
    typedef struct packed {
        logic              strm_rst;
        logic [GRBW_W-1:0] word;
    } out_ent_t;

    // Minimum of three channels as two chained 8-bit compares.
    function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        logic [PIX_W-1:0] ab;
        ab = (a < b) ? a : b;
        return (ab < c) ? ab : c;
    endfunction

    // Signed compare so a zero threshold never matches.
    function automatic logic below_thr(input logic [PIX_W-1:0] m, input int thr);
        return int'(m) < thr;
    endfunction

endpackage

// File: rtl/rgbw_out_buf.sv
// Circular output buffer of DEPTH entries with occupancy count and valid/ready read side.
// Write to rd_vld: 1 clk; head entry is presented directly from storage.
// Backpressure: rd_dat is held while rd_vld && !rd_rdy; writer is credit-limited upstream.
module rgbw_out_buf
    import rgbw_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  out_ent_t         wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output out_ent_t         rd_dat,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    out_ent_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push   = wr_vld && (count != CNT_W'(DEPTH));
    assign pop    = rd_vld && rd_rdy;
    assign rd_vld = (count != '0);
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    // Entry storage; contents are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rgb_2_rgbw_conv.sv
// Pops GRB pixels from the async FIFO, moves min(R,G,B) into a W lane, emits GRBW words.
// Latency: FIFO read strobe in cycle N -> out_valid in N+3 (empty buffer); 1 word/clk sustained.
// Backpressure: reads are credit-limited to OUT_BUF_DEPTH (in flight + buffered), so nothing drops.
module rgb_2_rgbw_conv
    import rgbw_pkg::*;
#(
    parameter int W_THRESH      = 0,
    parameter int OUT_BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_rd_fifo_empty,
    input  logic [IN_W-1:0]   in_rd_fifo_data,
    input  logic              in_bypass,
    input  logic              in_ready,
    output logic              out_rd_fifo_en,
    output logic              out_valid,
    output logic [GRBW_W-1:0] out_word,
    output logic              out_stream_reset
);

    localparam int CNT_W = $clog2(OUT_BUF_DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic             s1_vld;
    logic             s2_vld;
    stage_t           s2_dat;
    pix_t             s1_pix;
    out_ent_t         s3_dat;
    out_ent_t         buf_rd;
    logic [CNT_W-1:0] buf_cnt;
    logic [SUM_W-1:0] used;
    logic             unused_in_bits;

    // Assert asynchronously, release through two flops so every register leaves reset on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Credits are taken from registered state only; a slot freed by a transfer is reusable next cycle.
    assign used = SUM_W'(s1_vld) + SUM_W'(s2_vld) + SUM_W'(buf_cnt);
    assign out_rd_fifo_en = rst_n && !in_rd_fifo_empty && (used < SUM_W'(OUT_BUF_DEPTH));

    // FIFO read data is valid the cycle after the strobe; bypass is sampled with it, per word.
    assign s1_pix.g = in_rd_fifo_data[G_IN_LSB +: PIX_W];
    assign s1_pix.r = in_rd_fifo_data[R_IN_LSB +: PIX_W];
    assign s1_pix.b = in_rd_fifo_data[B_IN_LSB +: PIX_W];
    assign unused_in_bits = ^in_rd_fifo_data[IN_W-1:STRM_RST_BIT+1];

    // Pipeline valids and the min stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s2_dat <= '0;
        end else begin
            s1_vld <= out_rd_fifo_en;
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_dat.tok <= in_rd_fifo_data[STRM_RST_BIT];
                s2_dat.byp <= in_bypass;
                s2_dat.pix <= s1_pix;
                s2_dat.m   <= min3(s1_pix.g, s1_pix.r, s1_pix.b);
            end
        end
    end

    // Output word: tokens carry no pixel, bypassed/dim pixels pass through, others split off W.
    always_comb begin
        s3_dat = '0;
        if (s2_dat.tok) begin
            s3_dat.strm_rst = 1'b1;
        end else if (s2_dat.byp || below_thr(s2_dat.m, W_THRESH)) begin
            s3_dat.word[G_OUT_LSB +: PIX_W] = s2_dat.pix.g;
            s3_dat.word[R_OUT_LSB +: PIX_W] = s2_dat.pix.r;
            s3_dat.word[B_OUT_LSB +: PIX_W] = s2_dat.pix.b;
        end else begin
            s3_dat.word[G_OUT_LSB +: PIX_W] = s2_dat.pix.g - s2_dat.m;
            s3_dat.word[R_OUT_LSB +: PIX_W] = s2_dat.pix.r - s2_dat.m;
            s3_dat.word[B_OUT_LSB +: PIX_W] = s2_dat.pix.b - s2_dat.m;
            s3_dat.word[W_OUT_LSB +: PIX_W] = s2_dat.m;
        end
    end

    rgbw_out_buf #(
        .DEPTH (OUT_BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_out_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (s2_vld),
        .wr_dat (s3_dat),
        .rd_vld (out_valid),
        .rd_rdy (in_ready),
        .rd_dat (buf_rd),
        .count  (buf_cnt)
    );

    assign out_word         = buf_rd.word;
    assign out_stream_reset = buf_rd.strm_rst;

endmodule

// File: tb/tb_rgb_2_rgbw_conv.sv
module tb_rgb_2_rgbw_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [31:0] fifo_data = '0;
    logic        bypass;
    logic        ready;
    logic        rd_en0, vld0, srst0;
    logic        rd_en1, vld1, srst1;
    logic [31:0] word0, word1;

    logic [31:0] fifo_mem [64];
    int          wr_idx  = 0;
    int          rd_idx  = 0;
    int          en_diff = 0;

    logic [32:0] got0_q[$];
    logic [32:0] got1_q[$];
    logic [32:0] exp0_q[$];
    logic [32:0] exp1_q[$];
    int          gb0 = 0;
    int          gb1 = 0;
    int          eb  = 0;

    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_idx == rd_idx);

    rgb_2_rgbw_conv #(.W_THRESH(0), .OUT_BUF_DEPTH(4)) u_dut0 (
        .clk              (clk),
        .rst              (rst),
        .in_rd_fifo_empty (fifo_empty),
        .in_rd_fifo_data  (fifo_data),
        .in_bypass        (bypass),
        .in_ready         (ready),
        .out_rd_fifo_en   (rd_en0),
        .out_valid        (vld0),
        .out_word         (word0),
        .out_stream_reset (srst0)
    );

    rgb_2_rgbw_conv #(.W_THRESH(8), .OUT_BUF_DEPTH(4)) u_dut1 (
        .clk              (clk),
        .rst              (rst),
        .in_rd_fifo_empty (fifo_empty),
        .in_rd_fifo_data  (fifo_data),
        .in_bypass        (bypass),
        .in_ready         (ready),
        .out_rd_fifo_en   (rd_en1),
        .out_valid        (vld1),
        .out_word         (word1),
        .out_stream_reset (srst1)
    );

    // FIFO model: a strobe in cycle N pops, read data appears for cycle N+1.
    always @(posedge clk) begin
        if (rd_en0) begin
            fifo_data <= fifo_mem[rd_idx[5:0]];
            rd_idx    <= rd_idx + 1;
        end
        if (rd_en0 !== rd_en1) en_diff <= en_diff + 1;
    end

    // Record every transfer (valid && ready at the following edge).
    always @(negedge clk) begin
        if (vld0 && ready) got0_q.push_back({srst0, word0});
        if (vld1 && ready) got1_q.push_back({srst1, word1});
    end

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push_px(input logic [31:0] w, input logic tok,
                           input logic [31:0] e0, input logic [31:0] e1);
        fifo_mem[wr_idx[5:0]] = w;
        wr_idx = wr_idx + 1;
        exp0_q.push_back({tok, e0});
        exp1_q.push_back({tok, e1});
    endtask

    task automatic push_raw(input logic [31:0] w);
        fifo_mem[wr_idx[5:0]] = w;
        wr_idx = wr_idx + 1;
    endtask

    // Wait (bounded) for all expected words, then compare counts and contents in order.
    task automatic drain(input string tag);
        int cyc = 0;
        int n_exp;
        n_exp = exp0_q.size() - eb;
        while (((got0_q.size() - gb0) < n_exp || (got1_q.size() - gb1) < n_exp) && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        repeat (8) @(posedge clk);
        chk_val({tag, "_cnt0"}, 64'(got0_q.size() - gb0), 64'(n_exp));
        chk_val({tag, "_cnt1"}, 64'(got1_q.size() - gb1), 64'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            if (gb0 + i < got0_q.size())
                chk_val($sformatf("%s_d0_%0d", tag, i), 64'(got0_q[gb0 + i]), 64'(exp0_q[eb + i]));
            if (gb1 + i < got1_q.size())
                chk_val($sformatf("%s_d1_%0d", tag, i), 64'(got1_q[gb1 + i]), 64'(exp1_q[eb + i]));
        end
        gb0 = got0_q.size();
        gb1 = got1_q.size();
        eb  = exp0_q.size();
    endtask

    task automatic wait_issue(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (rd_en0) seen = 1'b1;
        end
        chk_val(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    initial begin
        int rd0;
        rst    = 1'b0;
        bypass = 1'b0;
        ready  = 1'b1;

        // Reset: a queued word must not be read while reset is held.
        push_px(32'h00408020, 1'b0, 32'h20600020, 32'h20600020);
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_valid", 64'(vld0), 64'd0);
        chk_val("rst_word",  64'(word0), 64'd0);
        chk_val("rst_srst",  64'(srst0), 64'd0);
        chk_val("rst_rd_en", 64'(rd_en0), 64'd0);

        // First word latency: strobe in N, out_valid first in N+3.
        rst = 1'b1;
        wait_issue("t1_issue");
        @(negedge clk);
        @(negedge clk);
        chk_val("t1_valid_n2", 64'(vld0), 64'd0);
        @(negedge clk);
        chk_val("t1_valid_n3", 64'(vld0), 64'd1);
        chk_val("t1_word_n3",  64'(word0), 64'h20600020);
        chk_val("t1_srst_n3",  64'(srst0), 64'd0);
        drain("t1");

        // Saturated and zero pixels, then bypass.
        @(posedge clk); #1;
        push_px(32'h00FFFFFF, 1'b0, 32'h000000FF, 32'h000000FF);
        push_px(32'h00000000, 1'b0, 32'h00000000, 32'h00000000);
        drain("t2");
        @(posedge clk); #1;
        bypass = 1'b1;
        push_px(32'h00408020, 1'b0, 32'h40802000, 32'h40802000);
        drain("t2_byp");
        @(posedge clk); #1;
        bypass = 1'b0;

        // Threshold: dut1 uses W_THRESH=8, dut0 W_THRESH=0.
        push_px(32'h00050505, 1'b0, 32'h00000005, 32'h05050500);
        push_px(32'h00090909, 1'b0, 32'h00000009, 32'h00000009);
        drain("t3");

        // Tokens between pixels, ignored upper bits, back-to-back.
        @(posedge clk); #1;
        push_px(32'h00301020, 1'b0, 32'h20001010, 32'h20001010);
        push_px(32'h01000000, 1'b1, 32'h00000000, 32'h00000000);
        push_px(32'h000A0B0C, 1'b0, 32'h0001020A, 32'h0001020A);
        push_px(32'hFE408020, 1'b0, 32'h20600020, 32'h20600020);
        push_px(32'h01FFFFFF, 1'b1, 32'h00000000, 32'h00000000);
        drain("t4");

        // Backpressure: only OUT_BUF_DEPTH reads while stalled, head held stable.
        @(posedge clk); #1;
        ready = 1'b0;
        rd0 = rd_idx;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] v;
            v = 8'(k + 1);
            push_px({8'h00, v, v, v}, 1'b0, {24'h0, v},
                    (k < 7) ? {v, v, v, 8'h00} : {24'h0, v});
        end
        repeat (20) @(posedge clk);
        #1;
        chk_val("t5_reads",  64'(rd_idx - rd0), 64'd4);
        chk_val("t5_valid",  64'(vld0), 64'd1);
        chk_val("t5_head0",  64'(word0), 64'h00000001);
        chk_val("t5_head1",  64'(word1), 64'h01010100);
        ready = 1'b1;
        drain("t5");

        // Mid-stream reset: w0..w2 popped and discarded, w3.. come out afterwards.
        @(posedge clk); #1;
        push_raw(32'h00102030);
        push_raw(32'h00112030);
        push_raw(32'h00122030);
        push_px(32'h00132030, 1'b0, 32'h000D1D13, 32'h000D1D13);
        push_px(32'h00142030, 1'b0, 32'h000C1C14, 32'h000C1C14);
        push_px(32'h00152030, 1'b0, 32'h000B1B15, 32'h000B1B15);
        wait_issue("t6_issue");
        repeat (3) @(posedge clk);
        #1;
        chk_val("t6_valid_pre", 64'(vld0), 64'd1);
        rst = 1'b0;
        #1;
        chk_val("t6_valid_rst", 64'(vld0), 64'd0);
        chk_val("t6_word_rst",  64'(word0), 64'd0);
        chk_val("t6_rd_en_rst", 64'(rd_en0), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        drain("t6");

        // Empty FIFO: no further read strobes.
        rd0 = rd_idx;
        repeat (10) @(posedge clk);
        #1;
        chk_val("t7_idle_reads", 64'(rd_idx - rd0), 64'd0);
        chk_val("rd_en_match", 64'(en_diff), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
